// File: rtl/cpu16_pkg.sv
// Shared constants and types for the 16-bit processor's sequential multiply unit.
package cpu16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int MUL_CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_datapath.sv
// Operand/accumulator registers and one-bit-per-cycle shift-add step; product and
// destination address registered at the capture strobe (optional sign fix-up under MUL_SIGNED_EN).
module mul_seq_datapath
    import cpu16_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int REG_AW_P = REG_AW
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load,
    input  logic                    step,
    input  logic                    capture,
    input  logic [DATA_W_P-1:0]     src_a,
    input  logic [DATA_W_P-1:0]     src_b,
    input  logic [REG_AW_P-1:0]     rd_addr,
    output logic [2*DATA_W_P-1:0]   product,
    output logic [REG_AW_P-1:0]     wr_addr
);

    logic [DATA_W_P-1:0]   a_reg;
    logic [DATA_W_P-1:0]   b_reg;
    logic [DATA_W_P-1:0]   acc_hi;
    logic [REG_AW_P-1:0]   rd_lat;
    logic [DATA_W_P:0]     sum;
    logic [2*DATA_W_P-1:0] raw_next;
    logic [DATA_W_P-1:0]   a_in;
    logic [DATA_W_P-1:0]   b_in;
    logic [2*DATA_W_P-1:0] prod_fixed;

`ifdef MUL_SIGNED_EN
    logic sign_reg;
    assign a_in = src_a[DATA_W_P-1] ? (DATA_W_P'(0) - src_a) : src_a;
    assign b_in = src_b[DATA_W_P-1] ? (DATA_W_P'(0) - src_b) : src_b;
    assign prod_fixed = sign_reg ? ((2*DATA_W_P)'(0) - raw_next) : raw_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sign_reg <= 1'b0;
        else if (load)
            sign_reg <= src_a[DATA_W_P-1] ^ src_b[DATA_W_P-1];
    end
`else
    assign a_in = src_a;
    assign b_in = src_b;
    assign prod_fixed = raw_next;
`endif

    // Carry kept in the DATA_W+1-bit sum; the final step's shifted value is the raw product.
    assign sum      = {1'b0, acc_hi} + (b_reg[0] ? {1'b0, a_reg} : '0);
    assign raw_next = {sum, b_reg[DATA_W_P-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_hi  <= '0;
            rd_lat  <= '0;
            product <= '0;
            wr_addr <= '0;
        end else begin
            if (load) begin
                a_reg  <= a_in;
                b_reg  <= b_in;
                acc_hi <= '0;
                rd_lat <= rd_addr;
            end else if (step) begin
                acc_hi <= sum[DATA_W_P:1];
                b_reg  <= {sum[0], b_reg[DATA_W_P-1:1]};
            end
            if (capture) begin
                product <= prod_fixed;
                wr_addr <= rd_lat;
            end
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Multi-cycle shift-add multiplier: stalls fetch while running, then one-cycle done/write strobe.
// Done arrives DATA_W+1 cycles after launch; back-to-back launch accepted in DONE. MUL_SIGNED_EN enables two's complement.
module mul_seq_unit
    import cpu16_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int REG_AW_P = REG_AW
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    mul_start,
    input  logic [DATA_W_P-1:0]     src_a,
    input  logic [DATA_W_P-1:0]     src_b,
    input  logic [REG_AW_P-1:0]     rd_addr,
    output logic                    mul_stall,
    output logic                    mul_done,
    output logic [2*DATA_W_P-1:0]   product,
    output logic                    wr_en,
    output logic [REG_AW_P-1:0]     wr_addr
);

    localparam int CNT_W = $clog2(DATA_W_P);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W_P - 1);

    mul_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load, step, capture;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mul_start) begin
                    load      = 1'b1;
                    mul_stall = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A new mul_start here is deliberately ignored; operands stay latched.
                mul_stall = 1'b1;
                step      = 1'b1;
                if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                mul_done = 1'b1;
                if (mul_start) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_en = mul_done;

    mul_seq_datapath #(
        .DATA_W_P (DATA_W_P),
        .REG_AW_P (REG_AW_P)
    ) u_datapath (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .step    (step),
        .capture (capture),
        .src_a   (src_a),
        .src_b   (src_b),
        .rd_addr (rd_addr),
        .product (product),
        .wr_addr (wr_addr)
    );

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed and random checks of mul_seq_unit against an arithmetic reference multiply.
module tb_mul_seq_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mul_start;
    logic [15:0] src_a, src_b;
    logic [2:0]  rd_addr;
    logic        mul_stall, mul_done, wr_en;
    logic [31:0] product;
    logic [2:0]  wr_addr;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_prod = 32'h0;

    always #5 clk = ~clk;

    mul_seq_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .mul_start (mul_start),
        .src_a     (src_a),
        .src_b     (src_b),
        .rd_addr   (rd_addr),
        .mul_stall (mul_stall),
        .mul_done  (mul_done),
        .product   (product),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr)
    );

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
`else
        logic [31:0] ua, ub;
        ua = {16'h0, a};
        ub = {16'h0, b};
        return ua * ub;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0: drive the launch, stall must already be high combinationally.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd);
        @(negedge clk);
        mul_start = 1'b1;
        src_a = a;
        src_b = b;
        rd_addr = rd;
        #1;
        check("stall_launch", 32'(mul_stall), 32'd1);
    endtask

    // Cycles 1..17 after launch; optional ignored pulse mid-run and optional chained launch in DONE.
    task automatic follow(input logic [31:0] exp_prod, input logic [2:0] exp_rd, input int pulse_at,
                          input bit chain, input logic [15:0] ca, input logic [15:0] cb,
                          input logic [2:0] crd);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) mul_start = 1'b0;
            if (pulse_at != 0 && k == pulse_at) begin
                mul_start = 1'b1;
                src_a = 16'd7;
                src_b = 16'd7;
                rd_addr = 3'd1;
            end
            if (pulse_at != 0 && k == pulse_at + 1) mul_start = 1'b0;
            if (k == 17 && chain) begin
                mul_start = 1'b1;
                src_a = ca;
                src_b = cb;
                rd_addr = crd;
            end
            #1;
            if (k < 17) begin
                check($sformatf("done_early_c%0d", k), 32'(mul_done), 32'd0);
                check($sformatf("wren_early_c%0d", k), 32'(wr_en), 32'd0);
                check($sformatf("stall_run_c%0d", k), 32'(mul_stall), 32'd1);
                if (k == 8) check("product_hold", product, last_prod);
            end else begin
                check("done_c17", 32'(mul_done), 32'd1);
                check("wren_c17", 32'(wr_en), 32'd1);
                check("product", product, exp_prod);
                check("wr_addr", 32'(wr_addr), 32'(exp_rd));
                check("stall_done", 32'(mul_stall), 32'd0);
                last_prod = exp_prod;
            end
        end
        if (!chain) begin
            @(negedge clk);
            #1;
            check("done_one_cycle", 32'(mul_done), 32'd0);
            check("wren_one_cycle", 32'(wr_en), 32'd0);
            check("product_after", product, exp_prod);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [2:0]  rr;
        bit          seen;

        rstn = 1'b0;
        mul_start = 1'b0;
        src_a = '0;
        src_b = '0;
        rd_addr = '0;
        #22;
        check("rst_stall", 32'(mul_stall), 32'd0);
        check("rst_done", 32'(mul_done), 32'd0);
        check("rst_wren", 32'(wr_en), 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed: 3*5 to r2.
        launch(16'd3, 16'd5, 3'd2);
        follow(32'h0000_000F, 3'd2, 0, 1'b0, '0, '0, '0);

        // Full-scale operands.
        launch(16'hFFFF, 16'hFFFF, 3'd7);
`ifdef MUL_SIGNED_EN
        follow(32'h0000_0001, 3'd7, 0, 1'b0, '0, '0, '0);
        launch(16'hFFFF, 16'h0003, 3'd3);
        follow(32'hFFFF_FFFD, 3'd3, 0, 1'b0, '0, '0, '0);
        launch(16'h8000, 16'h8000, 3'd4);
        follow(32'h4000_0000, 3'd4, 0, 1'b0, '0, '0, '0);
`else
        follow(32'hFFFE_0001, 3'd7, 0, 1'b0, '0, '0, '0);
        launch(16'h8000, 16'h8000, 3'd4);
        follow(32'h4000_0000, 3'd4, 0, 1'b0, '0, '0, '0);
`endif

        // Mid-run mul_start (7*7 -> r1) is ignored.
        launch(16'h1234, 16'h0056, 3'd5);
        follow(model(16'h1234, 16'h0056), 3'd5, 5, 1'b0, '0, '0, '0);

        // Back-to-back: 2*9 launched in the DONE cycle of 3*5.
        launch(16'd3, 16'd5, 3'd2);
        follow(32'h0000_000F, 3'd2, 0, 1'b1, 16'd2, 16'd9, 3'd6);
        follow(32'h0000_0012, 3'd6, 0, 1'b0, '0, '0, '0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rr = 3'($urandom_range(0, 7));
            launch(ra, rb, rr);
            follow(model(ra, rb), rr, 0, 1'b0, '0, '0, '0);
        end

        // Asynchronous reset at launch+8 aborts the multiply.
        launch(16'h0101, 16'h0202, 3'd5);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) mul_start = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_stall", 32'(mul_stall), 32'd0);
        check("abort_done", 32'(mul_done), 32'd0);
        check("abort_wren", 32'(wr_en), 32'd0);
        check("abort_product", product, 32'd0);
        check("abort_wr_addr", 32'(wr_addr), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        last_prod = 32'h0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (mul_done || wr_en) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_product_stays", product, 32'd0);

        // Recovery after abort.
        launch(16'd11, 16'd13, 3'd1);
        follow(32'd143, 3'd1, 0, 1'b0, '0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
